lfsr16_checker: RTL

//  Receive-side PRBS checker for the 16-bit LFSR generator. Self-synchronises to an incoming

---
 rtl/lfsr16_pkg.sv | 29 ++
 rtl/lfsr16_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lfsr16_pkg.sv
// ---------------------------------------------------------------------------
// lfsr16_pkg
// Shared definitions for the 16-bit PRBS generator/checker pair.
//  - lfsr16_next   : next-state function used by generator, checker and bench
//  - chk_state_t   : checker synchronisation state
//  - LFSR16_ZERO   : the all-zero lockup state, which the LFSR never leaves
// ---------------------------------------------------------------------------
package lfsr16_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  localparam logic [15:0] LFSR16_ZERO = 16'h0000;

  // One step of the 16-bit LFSR. Both the generator and the checker call this
  // so the two ends can never disagree on the sequence.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
    logic [15:0] n;
    n[15]   = q[15] ^ q[14];
    n[14:3] = q[13:2];
    n[2]    = q[15] ^ q[1];
    n[1]    = q[0];
    n[0]    = q[15];
    return n;
  endfunction

endpackage : lfsr16_pkg

// File: rtl/lfsr16_checker.sv
// ---------------------------------------------------------------------------
// lfsr16_checker
// Receive-side PRBS checker. Self-synchronises to a stream of full 16-bit
// generator states, then free-runs its own prediction and flags every word
// that disagrees with it.
//
// Ports
//  clk_in          in   1       system clock, posedge
//  rst_n_in        in   1       asynchronous active-low reset (deasserted
//                               synchronously inside this block)
//  data_in         in   16      received generator state
//  valid_in        in   1       data_in valid; when low nothing changes
//  clear_in        in   1       synchronous clear of the two counters only
//  locked_out      out  1       checker is LOCKED
//  err_pulse_out   out  1       one-cycle pulse for a mismatch while LOCKED
//  err_count_out   out  ERR_W   saturating count of LOCKED mismatches
//  word_count_out  out  WORD_W  wrapping count of words checked while LOCKED
// ---------------------------------------------------------------------------
module lfsr16_checker
  import lfsr16_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8,
  parameter int ERR_W      = 16,
  parameter int WORD_W     = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [15:0]       data_in,
  input  logic              valid_in,
  input  logic              clear_in,
  output logic              locked_out,
  output logic              err_pulse_out,
  output logic [ERR_W-1:0]  err_count_out,
  output logic [WORD_W-1:0] word_count_out
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = {ERR_W{1'b1}};

  // Reset synchroniser: assertion is immediate, release waits two clocks.
  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Two-flop reset release synchroniser.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // State and next-state.
  chk_state_t         state_r,     state_nxt_s;
  logic [15:0]        pred_r,      pred_nxt_s;
  logic [MATCH_W-1:0] match_cnt_r, match_cnt_nxt_s;
  logic [MISS_W-1:0]  miss_cnt_r,  miss_cnt_nxt_s;
  logic               locked_r,    locked_nxt_s;
  logic               err_pulse_r, err_pulse_nxt_s;
  logic [ERR_W-1:0]   err_cnt_r,   err_cnt_nxt_s;
  logic [WORD_W-1:0]  word_cnt_r,  word_cnt_nxt_s;

  // Checker state register and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r     <= SEARCH;
      pred_r      <= LFSR16_ZERO;
      match_cnt_r <= '0;
      miss_cnt_r  <= '0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_cnt_r   <= '0;
      word_cnt_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      pred_r      <= pred_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      miss_cnt_r  <= miss_cnt_nxt_s;
      locked_r    <= locked_nxt_s;
      err_pulse_r <= err_pulse_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      word_cnt_r  <= word_cnt_nxt_s;
    end
  end

  // Next-state: search/lock decisions, prediction and counter updates.
  always_comb begin
    state_nxt_s     = state_r;
    pred_nxt_s      = pred_r;
    match_cnt_nxt_s = match_cnt_r;
    miss_cnt_nxt_s  = miss_cnt_r;
    err_pulse_nxt_s = 1'b0;
    err_cnt_nxt_s   = err_cnt_r;
    word_cnt_nxt_s  = word_cnt_r;

    if (valid_in) begin
      case (state_r)
        SEARCH: begin
          // Always re-seed from the received word while searching.
          pred_nxt_s = lfsr16_next(data_in);
          if (data_in == LFSR16_ZERO) begin
            // Lockup word carries no sequence information.
            match_cnt_nxt_s = '0;
            pred_nxt_s      = LFSR16_ZERO;
          end else if ((data_in == pred_r) && (pred_r != LFSR16_ZERO)) begin
            if (match_cnt_r == MATCH_LAST) begin
              state_nxt_s     = LOCKED;
              match_cnt_nxt_s = '0;
              miss_cnt_nxt_s  = '0;
            end else begin
              match_cnt_nxt_s = match_cnt_r + MATCH_W'(1);
            end
          end else begin
            match_cnt_nxt_s = '0;
          end
        end

        LOCKED: begin
          // Free-run so a corrupted word cannot poison later predictions.
          pred_nxt_s     = lfsr16_next(pred_r);
          word_cnt_nxt_s = word_cnt_r + WORD_W'(1);
          if (data_in != pred_r) begin
            err_pulse_nxt_s = 1'b1;
            if (err_cnt_r != ERR_MAX) begin
              err_cnt_nxt_s = err_cnt_r + ERR_W'(1);
            end else begin
              err_cnt_nxt_s = err_cnt_r;
            end
            if (miss_cnt_r == MISS_LAST) begin
              // Too many misses in a row: drop back and re-seed.
              state_nxt_s     = SEARCH;
              match_cnt_nxt_s = '0;
              miss_cnt_nxt_s  = '0;
              pred_nxt_s      = lfsr16_next(data_in);
            end else begin
              miss_cnt_nxt_s = miss_cnt_r + MISS_W'(1);
            end
          end else begin
            miss_cnt_nxt_s = '0;
          end
        end

        default: begin
          state_nxt_s     = SEARCH;
          match_cnt_nxt_s = '0;
          miss_cnt_nxt_s  = '0;
        end
      endcase
    end else begin
      err_pulse_nxt_s = 1'b0;
    end

    // Clear overrides any same-cycle count update; the pulse still fires.
    if (clear_in) begin
      err_cnt_nxt_s  = '0;
      word_cnt_nxt_s = '0;
    end else begin
      err_cnt_nxt_s  = err_cnt_nxt_s;
      word_cnt_nxt_s = word_cnt_nxt_s;
    end
  end

  assign locked_nxt_s = (state_nxt_s == LOCKED);

  assign locked_out     = locked_r;
  assign err_pulse_out  = err_pulse_r;
  assign err_count_out  = err_cnt_r;
  assign word_count_out = word_cnt_r;

endmodule : lfsr16_checker
